// File: rtl/hs32_ahb_ram_if.sv
// AHB-Lite slave-side bus bundle for hs32_ahb_ram: address/data phase inputs and the slave's response.
// Combinational wiring only; the slave stalls the bus by holding HREADYOUT_o low.
interface hs32_ahb_ram_if;
  logic        HSEL_i;
  logic [31:0] HADDR_i;
  logic        HWRITE_i;
  logic [2:0]  HSIZE_i;
  logic [2:0]  HBURST_i;
  logic [3:0]  HPROT_i;
  logic        HMASTLOCK_i;
  logic [1:0]  HTRANS_i;
  logic        HREADY_i;
  logic [31:0] HWDATA_i;
  logic        HREADYOUT_o;
  logic        HRESP_o;
  logic [31:0] HRDATA_o;

  modport slave (
    input  HSEL_i, HADDR_i, HWRITE_i, HSIZE_i, HBURST_i, HPROT_i, HMASTLOCK_i,
    input  HTRANS_i, HREADY_i, HWDATA_i,
    output HREADYOUT_o, HRESP_o, HRDATA_o
  );

  modport master (
    output HSEL_i, HADDR_i, HWRITE_i, HSIZE_i, HBURST_i, HPROT_i, HMASTLOCK_i,
    output HTRANS_i, HREADY_i, HWDATA_i,
    input  HREADYOUT_o, HRESP_o, HRDATA_o
  );
endinterface

// File: rtl/hs32_ahb_ram.sv
// AHB-Lite word RAM slave: read data in the last data-phase cycle (1 cycle after accept + WAIT_STATES).
// Stalls via HREADYOUT_o during wait states and the first ERROR cycle; writes commit at data-phase end.
module hs32_ahb_ram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           resetn,
  hs32_ahb_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dp_vld_q, dp_vld_d;
  logic            dp_wr_q, dp_wr_d;
  logic [AW-1:0]   dp_idx_q, dp_idx_d;
  logic [1:0]      dp_off_q, dp_off_d;
  logic [2:0]      dp_size_q, dp_size_d;
  logic            byp_vld_q, byp_vld_d;
  logic [3:0]      byp_be_q, byp_be_d;
  logic [31:0]     byp_dat_q, byp_dat_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_dat_q;

  logic            addr_phase, accept, acc_err, wr_en;
  logic [3:0]      wr_be;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_merged;
  logic            unused_ok;

  assign addr_phase = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept     = addr_phase && bus.HSEL_i && bus.HREADY_i && bus.HTRANS_i[1];
  assign acc_err    = (|bus.HADDR_i[31:AW+2]) || (bus.HSIZE_i > 3'd2)
                   || ((bus.HSIZE_i == 3'd1) && bus.HADDR_i[0])
                   || ((bus.HSIZE_i == 3'd2) && (|bus.HADDR_i[1:0]));
  assign unused_ok  = ^{bus.HBURST_i, bus.HPROT_i, bus.HMASTLOCK_i, bus.HTRANS_i[0]};

  assign wr_en  = (state_q == ST_IDLE) && dp_vld_q && dp_wr_q;
  // The RAM re-reads the held index every stall cycle, so the final edge always sees committed data.
  assign rd_idx = addr_phase ? bus.HADDR_i[AW+1:2] : dp_idx_q;

  always_comb begin
    wr_be = 4'b1111;
    case (dp_size_q)
      3'd0:    wr_be = 4'b0001 << dp_off_q;
      3'd1:    wr_be = dp_off_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dp_vld_d  = dp_vld_q;
    dp_wr_d   = dp_wr_q;
    dp_idx_d  = dp_idx_q;
    dp_off_d  = dp_off_q;
    dp_size_d = dp_size_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d  = ST_IDLE;
        dp_vld_d = 1'b0;
        if (accept) begin
          dp_wr_d   = bus.HWRITE_i;
          dp_idx_d  = bus.HADDR_i[AW+1:2];
          dp_off_d  = bus.HADDR_i[1:0];
          dp_size_d = bus.HSIZE_i;
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            dp_vld_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write committing on the same edge the RAM is read would otherwise return stale lanes.
  always_comb begin
    byp_vld_d = wr_en && (dp_idx_q == rd_idx);
    byp_be_d  = wr_be;
    byp_dat_d = bus.HWDATA_i;
    for (int b = 0; b < 4; b++) begin
      rd_merged[b*8 +: 8] = (byp_vld_q && byp_be_q[b]) ? byp_dat_q[b*8 +: 8] : rd_dat_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      dp_vld_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_idx_q  <= '0;
      dp_off_q  <= 2'd0;
      dp_size_q <= 3'd0;
      byp_vld_q <= 1'b0;
      byp_be_q  <= 4'd0;
      byp_dat_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dp_vld_q  <= dp_vld_d;
      dp_wr_q   <= dp_wr_d;
      dp_idx_q  <= dp_idx_d;
      dp_off_q  <= dp_off_d;
      dp_size_q <= dp_size_d;
      byp_vld_q <= byp_vld_d;
      byp_be_q  <= byp_be_d;
      byp_dat_q <= byp_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) begin
        mem[dp_idx_q][b*8 +: 8] <= bus.HWDATA_i[b*8 +: 8];
      end
    end
    rd_dat_q <= mem[rd_idx];
  end

  assign bus.HREADYOUT_o = addr_phase;
  assign bus.HRESP_o     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign bus.HRDATA_o    = ((state_q == ST_IDLE) && dp_vld_q && !dp_wr_q) ? rd_merged : 32'd0;
endmodule
